// File: rtl/mips_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_mem_pkg                                                       |
// | Load/store opcodes, access state encoding and lane helper logic.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mips_mem_pkg;

    localparam logic [5:0] c_lb  = 6'b100000;
    localparam logic [5:0] c_lh  = 6'b100001;
    localparam logic [5:0] c_lwl = 6'b100010;
    localparam logic [5:0] c_lw  = 6'b100011;
    localparam logic [5:0] c_lbu = 6'b100100;
    localparam logic [5:0] c_lhu = 6'b100101;
    localparam logic [5:0] c_lwr = 6'b100110;
    localparam logic [5:0] c_sb  = 6'b101000;
    localparam logic [5:0] c_sh  = 6'b101001;
    localparam logic [5:0] c_sw  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Unknown opcodes fall through to the word rules everywhere below.
    function automatic logic access_aligned(input logic [5:0] op, input logic [1:0] k);
        case (op)
            c_lb, c_lbu, c_sb, c_lwl, c_lwr: access_aligned = 1'b1;
            c_lh, c_lhu, c_sh:               access_aligned = ~k[0];
            default:                         access_aligned = (k == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [5:0] op, input logic [1:0] k);
        case (op)
            c_lb, c_lbu, c_sb: lane_enables = 4'b0001 << k;
            c_lh, c_lhu, c_sh: lane_enables = k[1] ? 4'b1100 : 4'b0011;
            default:           lane_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [5:0] op, input logic [31:0] d);
        case (op)
            c_sb:    lane_replicate = {4{d[7:0]}};
            c_sh:    lane_replicate = {2{d[15:0]}};
            default: lane_replicate = d;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_access_load_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_align                                                         |
// | Formats a bus read word into the rt write-back value.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module load_align
    import mips_mem_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_k,
    input  logic [31:0] i_word,
    input  logic [31:0] i_rt_old,
    output logic [31:0] o_result
);

    logic [4:0]  w_rsh;
    logic [4:0]  w_lsh;
    logic [31:0] w_shr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_lwl_keep;

    always_comb begin
        // 8*k and 8*(3-k); for a 2-bit k, 3-k is simply ~k.
        w_rsh      = {i_k, 3'b000};
        w_lsh      = {~i_k, 3'b000};
        w_shr      = i_word >> w_rsh;
        w_byte     = w_shr[7:0];
        w_half     = i_k[1] ? i_word[31:16] : i_word[15:0];
        w_lwl_keep = (32'd1 << w_lsh) - 32'd1;
        case (i_opcode)
            c_lb:    o_result = {{24{w_byte[7]}}, w_byte};
            c_lbu:   o_result = {24'd0, w_byte};
            c_lh:    o_result = {{16{w_half[15]}}, w_half};
            c_lhu:   o_result = {16'd0, w_half};
            c_lwl:   o_result = (i_word << w_lsh) | (i_rt_old & w_lwl_keep);
            c_lwr:   o_result = w_shr | (i_rt_old & ~(32'hFFFF_FFFF >> w_rsh));
            default: o_result = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_access.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | data_mem_access                                                    |
// | One bus transaction per load/store with wait-request handshake.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module data_mem_access
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rt_old,
    output logic [ADDR_W-1:0] data_address,
    output logic              data_read,
    output logic              data_write,
    output logic [3:0]        data_byteenable,
    output logic [DATA_W-1:0] data_writedata,
    input  logic [DATA_W-1:0] data_readdata,
    input  logic              data_waitrequest,
    output logic              stall,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_result,
    output logic              addr_error
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_data_address;
    logic              r_data_read;
    logic              r_data_write;
    logic [3:0]        r_byteenable;
    logic [DATA_W-1:0] r_writedata;
    logic              r_load_valid;
    logic [DATA_W-1:0] r_load_result;
    logic [5:0]        r_opcode;
    logic [1:0]        r_k;
    logic [DATA_W-1:0] r_rt_old;

    logic              w_req;
    logic              w_aligned;
    logic [DATA_W-1:0] w_result;

    assign w_req     = (mem_read | mem_write) & ~reset;
    assign w_aligned = access_aligned(opcode, addr[1:0]);

    assign stall      = ((r_state == IDLE) && w_req && w_aligned) || (r_state == ACCESS);
    assign addr_error = (r_state == IDLE) && w_req && !w_aligned;

    assign data_address    = r_data_address;
    assign data_read       = r_data_read;
    assign data_write      = r_data_write;
    assign data_byteenable = r_byteenable;
    assign data_writedata  = r_writedata;
    assign load_valid      = r_load_valid;
    assign load_result     = r_load_result;

    load_align u_load_align (
        .i_opcode (r_opcode),
        .i_k      (r_k),
        .i_word   (data_readdata),
        .i_rt_old (r_rt_old),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_data_address <= '0;
            r_data_read    <= 1'b0;
            r_data_write   <= 1'b0;
            r_byteenable   <= 4'b0000;
            r_writedata    <= '0;
            r_load_valid   <= 1'b0;
            r_load_result  <= '0;
            r_opcode       <= 6'd0;
            r_k            <= 2'd0;
            r_rt_old       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_load_valid <= 1'b0;
                    if (w_req && w_aligned) begin
                        r_state        <= ACCESS;
                        r_data_address <= {addr[ADDR_W-1:2], 2'b00};
                        // A simultaneous read and write request is served as a read.
                        r_data_read    <= mem_read;
                        r_data_write   <= ~mem_read;
                        r_byteenable   <= lane_enables(opcode, addr[1:0]);
                        r_writedata    <= lane_replicate(opcode, store_data);
                        r_opcode       <= opcode;
                        r_k            <= addr[1:0];
                        r_rt_old       <= rt_old;
                    end
                end
                ACCESS: begin
                    if (!data_waitrequest) begin
                        r_state      <= DONE;
                        r_data_read  <= 1'b0;
                        r_data_write <= 1'b0;
                        r_load_valid <= r_data_read;
                        if (r_data_read) begin
                            r_load_result <= w_result;
                        end
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_load_valid <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_data_read  <= 1'b0;
                    r_data_write <= 1'b0;
                    r_load_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- Serves the memread/memwrite requests produced by the instruction decoder/control unit.
- Turns each load/store opcode into a single data-memory bus transaction on a word-addressed bus with a wait-request handshake.
- Generates byte enables and store lane replication, and returns sign/zero-extended or merged (LWL/LWR) load data.
- Holds the CPU pipeline with `stall` until the transaction completes.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, bus data width; fixed at 32, other values are not supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  load request from control (memread)
- mem_write  in  1  store request from control (memwrite)
- opcode  in  6  instruction[31:26]
- addr  in  32  effective byte address (rs + imm)
- store_data  in  32  rt value for stores
- rt_old  in  32  current rt value, merged by LWL/LWR
- data_address  out  32  word-aligned bus address, {addr[31:2],2'b00}
- data_read  out  1  bus read strobe
- data_write  out  1  bus write strobe
- data_byteenable  out  4  byte lanes
- data_writedata  out  32  lane-replicated store data
- data_readdata  in  32  bus read data
- data_waitrequest  in  1  bus not ready; hold the strobe
- stall  out  1  freeze PC and pipeline
- load_valid  out  1  load_result valid this cycle
- load_result  out  32  value to write into rt
- addr_error  out  1  misaligned access detected

Behaviour:
- Byte order: little-endian lanes; lane n = bits [8n+7:8n].
- States: IDLE, ACCESS, DONE.
- Reset: state IDLE; data_read, data_write, load_valid, addr_error = 0; byteenable = 0; address, writedata, load_result = 0.
- Reset asserted mid-ACCESS: strobes drop the next cycle and the transaction is abandoned.
- IDLE:
  - If mem_read or mem_write is high and the access is aligned, latch opcode, addr, store_data and rt_old, then go to ACCESS.
  - stall = 1 combinationally in this cycle.
  - If both requests are high, the read wins.
- Alignment rules:
  - LW/SW require addr[1:0] == 0.
  - LH/LHU/SH require addr[0] == 0.
  - LB/LBU/SB/LWL/LWR are always aligned.
  - On a misaligned request, addr_error = 1 combinationally, stall = 0, no bus cycle is issued, and the state stays IDLE.
- ACCESS:
  - data_read or data_write = 1, driven from the latched values; stall = 1.
  - While data_waitrequest = 1, hold all bus outputs stable.
  - On the first cycle with data_waitrequest = 0: capture the formatted load_result (loads only), then go to DONE.
- DONE:
  - stall = 0; strobes = 0.
  - load_valid = 1 for loads, 0 for stores; load_result is held.
  - Requests present in this cycle belong to the completing instruction and are ignored.
  - Next state is IDLE.
- Minimum cost per access: 2 stall cycles; each waitrequest cycle adds 1.
- Byte enables:
  - SB/LB/LBU: 1 << addr[1:0].
  - SH/LH/LHU: addr[1] ? 4'b1100 : 4'b0011.
  - SW/LW/LWL/LWR: 4'b1111.
- Store data:
  - SB: {4{store_data[7:0]}}.
  - SH: {2{store_data[15:0]}}.
  - SW: store_data unchanged.
- Load formatting (k = addr[1:0]; b = selected lane; h = selected halfword):
  - LB: sign-extend b.
  - LBU: zero-extend b.
  - LH: sign-extend h.
  - LHU: zero-extend h.
  - LW: full word.
  - LWL: (word << 8*(3-k)) | (rt_old & ((1 << 8*(3-k)) - 1)).
  - LWR: (word >> 8k) | (rt_old & ~(32'hFFFFFFFF >> 8k)).
- Unknown opcode while mem_read or mem_write is high: treat as a word access.

Decomposition:
- Package mips_mem_pkg holds:
  - load/store opcode localparams: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110, SB 101000, SH 101001, SW 101011;
  - the state enum {IDLE, ACCESS, DONE}.
- One sub-module, load_align: purely combinational, taking (opcode, k, word, rt_old) to the formatted result. It is instantiated once and feeds the load_result register.

Test Plan:
- LW at addr 0x1004, waitrequest low, readdata 0xDEADBEEF -> data_address 0x1004, byteenable 1111, stall high 2 cycles, load_valid with 0xDEADBEEF in DONE.
- LB at addr 0x1003, readdata 0x80FF1234 -> byteenable 1000, load_result 0xFFFFFF80. The same access with LBU -> 0x00000080.
- SH at addr 0x2002, store_data 0x0000ABCD, waitrequest high 3 cycles -> data_write held 4 cycles with byteenable 1100 and writedata 0xABCDABCD, stall high 5 cycles, load_valid stays 0.
- LWL at addr k=1, readdata 0x44332211, rt_old 0xAABBCCDD -> load_result 0x2211CCDD. LWR at k=2, same data -> 0xAABB4433.
- LW at addr 0x1002 -> addr_error 1, stall 0, no data_read. The next aligned request proceeds normally.
- Reset during ACCESS with waitrequest held high -> strobes 0 the next cycle, state IDLE, load_valid never asserted.
